ascon_sbox_layer_seq: RTL and testbench

Sequencer that applies the Ascon 5-bit substitution layer to a full W-slice Ascon state using one shared external 5-bit S-box instance, one bit-slice per clock. It loads the state on a start handshake and presents each slice to the S-box. It writes each S-box result back into the working state and signals completion with a one-cycle done pulse. It sits between the permutation round controller and the shared S-box instance.

---
 rtl/ascon_sbox_layer_seq.sv | 148 ++++++++++++++
 tb/tb_ascon_sbox_layer_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_sbox_layer_seq.sv
// Ascon substitution layer sequencer: streams the W bit-slices of a
// five-word state through one shared 5-bit S-box, one slice per clock.
module ascon_sbox_layer_seq #(
   parameter int W        = 64,
   parameter int SBOX_LAT = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [5*W-1:0] state_in,
   output logic           busy,
   output logic           done,
   output logic [5*W-1:0] state_out,
   output logic           sbox_act,
   output logic [4:0]     sbox_in,
   input  logic [4:0]     sbox_out
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t st_q, st_d;

   logic [IW-1:0] iss_q, iss_d;
   logic [IW-1:0] cap_q, cap_d;

   // Row b holds the word feeding S-box bit b (row 4 = x0, row 0 = x4).
   logic [4:0][W-1:0] work_q, work_d;
   logic [4:0][W-1:0] merged;

   logic [5*W-1:0] out_q, out_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           wr_en;
   logic [IW-1:0]  wr_idx;

   // With a registered S-box the result belongs to the previous issue.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = iss_q;
      if (SBOX_LAT == 0) begin
         wr_en = (st_q == RUN);
      end else begin
         wr_en  = ((st_q == RUN) && (iss_q != '0)) || (st_q == DRAIN);
         wr_idx = cap_q;
      end
   end

   always_comb begin
      merged = work_q;
      if (wr_en) begin
         for (int b = 0; b < 5; b++) begin
            merged[b][wr_idx] = sbox_out[b];
         end
      end
   end

   always_comb begin
      st_d     = st_q;
      iss_d    = iss_q;
      cap_d    = cap_q;
      work_d   = merged;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sbox_act = 1'b0;
      sbox_in  = '0;

      unique case (st_q)
         IDLE: begin
            if (start) begin
               work_d = state_in;
               iss_d  = '0;
               cap_d  = '0;
               busy_d = 1'b1;
               st_d   = RUN;
            end
         end

         RUN: begin
            sbox_act = 1'b1;
            for (int b = 0; b < 5; b++) begin
               sbox_in[b] = work_q[b][iss_q];
            end
            cap_d = iss_q;
            if (iss_q == LAST) begin
               if (SBOX_LAT == 0) begin
                  out_d  = merged;
                  done_d = 1'b1;
                  busy_d = 1'b0;
                  iss_d  = '0;
                  cap_d  = '0;
                  st_d   = IDLE;
               end else begin
                  st_d = DRAIN;
               end
            end else begin
               iss_d = iss_q + IW'(1);
            end
         end

         DRAIN: begin
            out_d  = merged;
            done_d = 1'b1;
            busy_d = 1'b0;
            iss_d  = '0;
            cap_d  = '0;
            st_d   = IDLE;
         end

         default: begin
            st_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         iss_q  <= '0;
         cap_q  <= '0;
         work_q <= '0;
         out_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         iss_q  <= iss_d;
         cap_q  <= cap_d;
         work_q <= work_d;
         out_q  <= out_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign state_out = out_q;

endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// Bench for ascon_sbox_layer_seq: a W=64 combinational-S-box instance and
// a W=8 registered-S-box instance checked against a whole-state model.
module tb_ascon_sbox_layer_seq;

   logic clk;
   logic rst_n;

   logic         start0, busy0, done0, act0;
   logic [319:0] sin0, sout0;
   logic [4:0]   sbi0, sbo0;

   logic         start1, busy1, done1, act1;
   logic [39:0]  sin1, sout1;
   logic [4:0]   sbi1, sbo1;

   int checks = 0;
   int errors = 0;

   logic [4:0] SB [32];

   initial begin
      SB = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared S-box models: zero latency for DUT0, one register for DUT1.
   assign sbo0 = SB[sbi0];
   always @(posedge clk) sbo1 <= SB[sbi1];

   ascon_sbox_layer_seq #(.W(64), .SBOX_LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .state_in(sin0),
      .busy(busy0), .done(done0), .state_out(sout0),
      .sbox_act(act0), .sbox_in(sbi0), .sbox_out(sbo0)
   );

   ascon_sbox_layer_seq #(.W(8), .SBOX_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .state_in(sin1),
      .busy(busy1), .done(done1), .state_out(sout1),
      .sbox_act(act1), .sbox_in(sbi1), .sbox_out(sbo1)
   );

   // Whole-state model: bit b of slice i sits at position b*w+i.
   function automatic logic [319:0] ref_layer(input logic [319:0] st,
                                              input int w);
      logic [319:0] r;
      logic [4:0]   v;
      logic [4:0]   s;
      r = '0;
      for (int i = 0; i < w; i++) begin
         for (int b = 0; b < 5; b++) v[b] = st[b*w+i];
         s = SB[v];
         for (int b = 0; b < 5; b++) r[b*w+i] = s[b];
      end
      return r;
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs,
                      input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_pass(input int d, input logic [319:0] st,
                          output int lat, output logic [319:0] res);
      @(negedge clk);
      if (d == 0) begin
         sin0   = st;
         start0 = 1'b1;
      end else begin
         sin1   = st[39:0];
         start1 = 1'b1;
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      chk("busy_after_start", {319'b0, (d == 0) ? busy0 : busy1}, 320'd1);
      sin0 = rnd320();
      sin1 = 40'(rnd320());
      lat  = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (((d == 0) ? done0 : done1) === 1'b1) begin
            lat = n;
            break;
         end
      end
      res = (d == 0) ? sout0 : {280'b0, sout1};
      chk("busy_at_done", {319'b0, (d == 0) ? busy0 : busy1}, 320'd0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {319'b0, (d == 0) ? done0 : done1}, 320'd0);
      chk("state_out_held", (d == 0) ? sout0 : {280'b0, sout1}, res);
   endtask

   logic [319:0] st, res, exp;
   int           lat, ndone, first, second;
   logic         busy_nxt;

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      sin0   = '0;
      sin1   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy0", {319'b0, busy0}, 320'd0);
      chk("rst_done0", {319'b0, done0}, 320'd0);
      chk("rst_act0", {319'b0, act0}, 320'd0);
      chk("rst_sbi0", {315'b0, sbi0}, 320'd0);
      chk("rst_out0", sout0, 320'd0);
      chk("rst_busy1", {319'b0, busy1}, 320'd0);
      chk("rst_done1", {319'b0, done1}, 320'd0);
      chk("rst_out1", {280'b0, sout1}, 320'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All-zero state: every slice maps 0x00 -> 0x04, so x2 becomes all ones.
      do_pass(0, 320'd0, lat, res);
      chk("zero_lat", 320'(lat), 320'd64);
      chk("zero_out", res, {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
      chk("idle_act0", {319'b0, act0}, 320'd0);
      chk("idle_sbi0", {315'b0, sbi0}, 320'd0);

      // x0 all ones: 0x10 -> 0x1E.
      st = {64'hFFFF_FFFF_FFFF_FFFF, 256'h0};
      do_pass(0, st, lat, res);
      chk("x0ones_lat", 320'(lat), 320'd64);
      chk("x0ones_out", res, {{4{64'hFFFF_FFFF_FFFF_FFFF}}, 64'h0});

      // W=8 registered S-box, x4=0x01.
      do_pass(1, {280'b0, 40'h00_00_00_00_01}, lat, res);
      chk("lat1_lat", 320'(lat), 320'd9);
      chk("lat1_out", res, {280'b0, 8'h00, 8'h01, 8'hFE, 8'h01, 8'h01});
      chk("idle_act1", {319'b0, act1}, 320'd0);

      for (int k = 0; k < 4; k++) begin
         st = rnd320();
         do_pass(0, st, lat, res);
         chk("rnd0_lat", 320'(lat), 320'd64);
         chk("rnd0_out", res, ref_layer(st, 64));
         st = {280'b0, 40'(rnd320())};
         do_pass(1, st, lat, res);
         chk("rnd1_lat", 320'(lat), 320'd9);
         chk("rnd1_out", res, ref_layer(st, 8));
      end

      // start held high: one done per pass, next pass begins right after done.
      st = {280'b0, 40'(rnd320())};
      @(negedge clk);
      sin1   = st[39:0];
      start1 = 1'b1;
      @(posedge clk);
      #1;
      ndone    = 0;
      first    = -1;
      second   = -1;
      busy_nxt = 1'b0;
      for (int n = 1; n <= 25; n++) begin
         @(posedge clk);
         #1;
         if (n == 10) busy_nxt = busy1;
         if (done1 === 1'b1) begin
            ndone++;
            if (first < 0) first = n;
            else second = n;
         end
      end
      start1 = 1'b0;
      chk("held_ndone", 320'(ndone), 320'd2);
      chk("held_first", 320'(first), 320'd9);
      chk("held_second", 320'(second), 320'd19);
      chk("held_busy_next", {319'b0, busy_nxt}, 320'd1);
      chk("held_out", {280'b0, sout1}, ref_layer(st, 8));
      for (int n = 0; n < 20 && busy1; n++) @(posedge clk);
      #1;
      chk("held_drained", {319'b0, busy1}, 320'd0);

      // Reset at slice 20 of a W=64 pass.
      @(negedge clk);
      sin0   = rnd320();
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_busy", {319'b0, busy0}, 320'd0);
      chk("midrst_out", sout0, 320'd0);
      ndone = 0;
      for (int n = 0; n < 70; n++) begin
         @(posedge clk);
         #1;
         if (done0 === 1'b1) ndone++;
      end
      chk("midrst_nodone", 320'(ndone), 320'd0);
      chk("midrst_out_kept", sout0, 320'd0);

      st = rnd320();
      do_pass(0, st, lat, res);
      chk("postrst_lat", 320'(lat), 320'd64);
      chk("postrst_out", res, ref_layer(st, 64));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
